// File: rtl/counter_prescaled_updown.sv
// Purpose : prescaled modulo-MODULUS up/down counter with load, one-shot stop and cascadable rco.
// Latency : count updates on the mclk edge where tick=1; load_value appears on count one cycle after load.
// Backpres: enable=0 freezes prescaler, count and done; load overrides enable; rco drives the next stage's enable.
//
// Ports:
//   mclk        master clock, all state on its rising edge
//   reset       synchronous active-high reset (highest priority)
//   enable      prescaler/counter enable; low holds all state
//   up_down     1 = count up, 0 = count down; selects terminal value
//   one_shot    0 = wrap at terminal, 1 = stop at terminal and raise done
//   load        synchronous load strobe (beats tick, loses to reset)
//   load_value  value to load, clamped to MODULUS-1
//   count       registered current count
//   tick        one-cycle prescaler pulse every DIV enabled cycles
//   rco         ripple-carry pulse on the terminal-count tick
//   done        sticky one-shot terminal flag, cleared by load or reset

module counter_prescaled_updown #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256,
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             rco,
  output logic             done
);

  localparam int               DIV      = CLK_HZ / TICK_HZ;
  localparam int               PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MODULUS - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [WIDTH-1:0] terminal;
  logic             at_terminal;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_next_tick;
  logic             advance;

  // ---------------------------------------------------------------------------
  // Combinational decode from registered state and current inputs
  // ---------------------------------------------------------------------------
  always_comb begin
    terminal     = up_down ? CNT_MAX : '0;
    at_terminal  = (count == terminal);
    tick         = enable && (pre_cnt == PRE_LAST);
    // Once done is set the counter is parked, so neither advancing nor carrying.
    advance      = tick && !done;
    // A load on a tick edge replaces the increment, so the carry must not escape.
    rco          = advance && at_terminal && !load;
    load_clamped = (load_value > CNT_MAX) ? CNT_MAX : load_value;

    // Wrap targets are explicit because MODULUS need not be a power of two.
    if (at_terminal) begin
      count_next_tick = up_down ? '0 : CNT_MAX;
    end else if (up_down) begin
      count_next_tick = count + WIDTH'(1);
    end else begin
      count_next_tick = count - WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler: free-running 0..DIV-1 while enabled, restarted by load
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (load) begin
      pre_cnt <= '0;
    end else if (enable) begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Count and sticky done flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk) begin
    if (reset) begin
      count <= '0;
      done  <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      done  <= 1'b0;
    end else if (advance) begin
      if (at_terminal && one_shot) begin
        // Stop on the terminal value; only load/reset can restart.
        done <= 1'b1;
      end else begin
        count <= count_next_tick;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Behavioural properties (ignored by synthesis)
  // ---------------------------------------------------------------------------
  tick_single_cycle : assert property (@(posedge mclk) tick |=> !tick);
  rco_needs_tick    : assert property (@(posedge mclk) rco |-> tick);
  done_holds_count  : assert property (@(posedge mclk)
                        (done && !load && !reset) |=> (done && $stable(count)));
  reset_clears      : assert property (@(posedge mclk)
                        reset |=> (count == '0 && !done && pre_cnt == '0));

endmodule

// File: tb/tb_counter_prescaled_updown.sv
// Purpose : self-checking bench for counter_prescaled_updown (WIDTH=4, MODULUS=12, DIV=10).
// Latency : inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpres: n/a; reference model steps once per rising edge.

module tb_counter_prescaled_updown;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 12;
  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  logic             mclk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             up_down = 1'b1;
  logic             one_shot = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             rco;
  logic             done;

  always #5 mclk = ~mclk;

  counter_prescaled_updown #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) dut (
    .mclk       (mclk),
    .reset      (reset),
    .enable     (enable),
    .up_down    (up_down),
    .one_shot   (one_shot),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .tick       (tick),
    .rco        (rco),
    .done       (done)
  );

  // Requested input values for the next cycle
  logic d_rst = 1'b1, d_en = 1'b0, d_ud = 1'b1, d_os = 1'b0, d_ld = 1'b0;
  int   d_lv  = 0;

  // Reference model: count value, prescaler phase and stop flag as plain integers
  int m_count = 0;
  int m_pre   = 0;
  bit m_done  = 1'b0;
  bit m_valid = 1'b0;

  // Most recent sampled DUT outputs
  logic             obs_tick, obs_rco, obs_done;
  logic [WIDTH-1:0] obs_count;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, sample, compare against model, then step the model.
  task automatic cyc();
    bit exp_tick, exp_rco, at_term;
    int term, step;
    @(negedge mclk);
    reset      = d_rst;
    enable     = d_en;
    up_down    = d_ud;
    one_shot   = d_os;
    load       = d_ld;
    load_value = WIDTH'(d_lv);
    #1;
    obs_tick  = tick;
    obs_rco   = rco;
    obs_done  = done;
    obs_count = count;

    term     = d_ud ? MODULUS - 1 : 0;
    step     = d_ud ? 1 : MODULUS - 1;
    at_term  = (m_count == term);
    exp_tick = d_en && (m_pre == DIV - 1);
    exp_rco  = exp_tick && at_term && !m_done && !d_ld;
    if (m_valid) begin
      chk("tick",  {31'd0, obs_tick}, {31'd0, exp_tick});
      chk("rco",   {31'd0, obs_rco},  {31'd0, exp_rco});
      chk("done",  {31'd0, obs_done}, {31'd0, m_done});
      chk("count", 32'(obs_count),    32'(m_count));
    end

    @(posedge mclk);
    if (d_rst) begin
      m_count = 0;
      m_pre   = 0;
      m_done  = 1'b0;
      m_valid = 1'b1;
    end else if (d_ld) begin
      m_count = (d_lv > MODULUS - 1) ? MODULUS - 1 : d_lv;
      m_pre   = 0;
      m_done  = 1'b0;
    end else if (d_en) begin
      if (exp_tick && !m_done) begin
        if (at_term && d_os) m_done = 1'b1;
        else                 m_count = (m_count + step) % MODULUS;
      end
      m_pre = (m_pre + 1) % DIV;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Returns the 0-based index of the cycle in which tick is observed.
  task automatic wait_tick(output int idx);
    idx = 0;
    forever begin
      cyc();
      if (obs_tick === 1'b1) break;
      idx++;
      if (idx >= 3 * DIV) begin
        chk("wait_tick_timeout", {31'd0, obs_tick}, 32'd1);
        break;
      end
    end
  endtask

  initial begin
    int n;
    int guard;

    // Reset, then free-run up from count 0
    run(2);
    d_rst = 1'b0;
    d_en  = 1'b1;
    for (int i = 0; i <= 120; i++) begin
      cyc();
      if (i == 0) begin
        chk("reset_count", 32'(obs_count), 32'd0);
        chk("reset_done",  {31'd0, obs_done}, 32'd0);
        chk("reset_tick",  {31'd0, obs_tick}, 32'd0);
        chk("reset_rco",   {31'd0, obs_rco},  32'd0);
      end
      if (i == 8)   chk("no_early_tick", {31'd0, obs_tick}, 32'd0);
      if (i == 9)   chk("first_tick",    {31'd0, obs_tick}, 32'd1);
      if (i == 10)  chk("first_count",   32'(obs_count), 32'd1);
      if (i == 119) begin
        chk("up_term_count", 32'(obs_count), 32'd11);
        chk("up_wrap_rco",   {31'd0, obs_rco}, 32'd1);
      end
      if (i == 120) chk("up_wrap_count", 32'(obs_count), 32'd0);
    end

    // Down wrap from 0
    d_ud = 1'b0;
    wait_tick(n);
    chk("down_rco", {31'd0, obs_rco}, 32'd1);
    cyc();
    chk("down_wrap", 32'(obs_count), 32'd11);
    wait_tick(n);
    cyc();
    chk("down_next", 32'(obs_count), 32'd10);

    // One-shot up from 9
    d_ud = 1'b1; d_os = 1'b1; d_ld = 1'b1; d_lv = 9;
    cyc();
    d_ld = 1'b0;
    wait_tick(n);
    wait_tick(n);
    wait_tick(n);
    chk("oneshot_rco", {31'd0, obs_rco}, 32'd1);
    cyc();
    chk("oneshot_done",  {31'd0, obs_done}, 32'd1);
    chk("oneshot_count", 32'(obs_count), 32'd11);
    wait_tick(n);
    chk("oneshot_hold_rco", {31'd0, obs_rco}, 32'd0);
    d_os = 1'b0;   // clearing one_shot must not restart
    wait_tick(n);
    cyc();
    chk("oneshot_sticky", {31'd0, obs_done}, 32'd1);
    d_ld = 1'b1; d_lv = 3;
    cyc();
    d_ld = 1'b0;
    cyc();
    chk("reload_done",  {31'd0, obs_done}, 32'd0);
    chk("reload_count", 32'(obs_count), 32'd3);

    // Load clamp
    d_ld = 1'b1; d_lv = 15;
    cyc();
    d_ld = 1'b0;
    cyc();
    chk("load_clamp", 32'(obs_count), 32'd11);

    // Load on a tick edge beats the increment
    d_ld = 1'b1; d_lv = 5;
    cyc();
    d_ld = 1'b0;
    run(DIV - 1);
    d_ld = 1'b1; d_lv = 2;
    cyc();
    chk("prio_tick", {31'd0, obs_tick}, 32'd1);
    chk("prio_rco",  {31'd0, obs_rco},  32'd0);
    d_ld = 1'b0;
    cyc();
    chk("prio_count", 32'(obs_count), 32'd2);
    // One cycle already spent after the load edge; tick lands DIV cycles after it.
    wait_tick(n);
    chk("prio_next_tick", 32'(n), 32'(DIV - 2));

    // Enable freeze at prescaler phase 4
    guard = 0;
    while (m_pre != 4 && guard < 2 * DIV) begin
      cyc();
      guard++;
    end
    d_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("freeze_tick", {31'd0, obs_tick}, 32'd0);
    end
    d_en = 1'b1;
    wait_tick(n);
    chk("resume_tick", 32'(n), 32'd5);

    // Reset on a terminal tick with load asserted
    d_ld = 1'b1; d_lv = 11;
    cyc();
    d_ld = 1'b0;
    run(DIV - 1);
    d_rst = 1'b1; d_ld = 1'b1; d_lv = 7;
    cyc();
    chk("rst_on_tick", {31'd0, obs_tick}, 32'd1);
    d_rst = 1'b0; d_ld = 1'b0;
    cyc();
    chk("rst_count", 32'(obs_count), 32'd0);
    chk("rst_done",  {31'd0, obs_done}, 32'd0);
    chk("rst_rco",   {31'd0, obs_rco},  32'd0);
    wait_tick(n);
    chk("rst_next_tick", 32'(n), 32'(DIV - 2));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      d_rst = ($urandom_range(0, 199) == 0);
      d_ld  = ($urandom_range(0, 24) == 0);
      d_en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) d_ud = ~d_ud;
      if ($urandom_range(0, 59) == 0) d_os = ~d_os;
      d_lv  = $urandom_range(0, 15);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
